// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
//   Shared definitions for the pipeline stage register and its entry storage:
//   occupancy state encoding, default Tnew field width and fixed field widths.
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  // Field widths of an instruction entry that are fixed by the ISA.
  localparam int INS_W  = 32;
  localparam int PC_W   = 32;
  localparam int REGA_W = 5;

  // Default width of the Tnew (cycles-until-result) field.
  localparam int TNEW_W_DEFAULT = 2;

  // Width of the occupancy count (0..2 entries).
  localparam int OCC_W = 2;

  // Stage occupancy state; the numeric value doubles as the entry count.
  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_stage_reg_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
//   One instruction entry: a load-enabled register over all entry fields with
//   a synchronous clear. Clear has priority over load.
//
// Ports
//   clk                         rising-edge clock
//   clear                       synchronous clear of all fields to zero
//   load                        capture the d_* fields this cycle
//   d_ins/d_pc/d_data/d_regwrite/d_regwa/d_tnew   next entry fields
//   q_ins/q_pc/q_data/q_regwrite/q_regwa/q_tnew   held entry fields
// ---------------------------------------------------------------------------
module pipe_entry_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TNEW_W = TNEW_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [INS_W-1:0]  d_ins,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_regwrite,
  input  logic [REGA_W-1:0] d_regwa,
  input  logic [TNEW_W-1:0] d_tnew,
  output logic [INS_W-1:0]  q_ins,
  output logic [PC_W-1:0]   q_pc,
  output logic [DATA_W-1:0] q_data,
  output logic              q_regwrite,
  output logic [REGA_W-1:0] q_regwa,
  output logic [TNEW_W-1:0] q_tnew
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q_ins      <= '0;
      q_pc       <= '0;
      q_data     <= '0;
      q_regwrite <= 1'b0;
      q_regwa    <= '0;
      q_tnew     <= '0;
    end else if (load) begin
      q_ins      <= d_ins;
      q_pc       <= d_pc;
      q_data     <= d_data;
      q_regwrite <= d_regwrite;
      q_regwa    <= d_regwa;
      q_tnew     <= d_tnew;
    end
  end

endmodule : pipe_entry_reg

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Two-entry pipeline stage register with valid/ready handshake. The main
//   entry drives the outputs; a skid entry absorbs one extra push so that
//   in_ready can be a register (no combinational path from out_ready).
//   Tnew is optionally decremented (saturating at 0) on capture.
//   While no entry is held the outputs present a bubble (all fields zero),
//   so downstream hazard logic never sees a phantom producer.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               discard all held entries (push/pop ignored that cycle)
//   in_valid/in_ready   upstream handshake; in_ready is registered
//   in_*                incoming entry fields
//   out_valid/out_ready downstream handshake for the head entry
//   out_*               head entry fields (zero while out_valid=0)
//   occupancy           number of held entries, 0..2
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int TNEW_W   = TNEW_W_DEFAULT,
  parameter int TNEW_DEC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INS_W-1:0]  in_ins,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_regwrite,
  input  logic [REGA_W-1:0] in_regwa,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INS_W-1:0]  out_ins,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_regwrite,
  output logic [REGA_W-1:0] out_regwa,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [OCC_W-1:0]  occupancy
);

  // -------------------------------------------------------------------------
  // State and registered handshake
  // -------------------------------------------------------------------------
  stage_state_t state;
  stage_state_t state_next;
  logic         in_ready_reg;

  logic push;
  logic pop;
  logic clear;

  assign in_ready  = in_ready_reg;
  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  assign push  = in_valid && in_ready_reg;
  assign pop   = out_valid && out_ready;
  assign clear = reset || flush;

  // -------------------------------------------------------------------------
  // Tnew on capture: saturating decrement or pass-through
  // -------------------------------------------------------------------------
  logic [TNEW_W-1:0] cap_tnew;

  generate
    if (TNEW_DEC != 0) begin : g_tnew_dec
      assign cap_tnew = (in_tnew == '0) ? '0 : (in_tnew - TNEW_W'(1));
    end else begin : g_tnew_pass
      assign cap_tnew = in_tnew;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Entry storage
  // -------------------------------------------------------------------------
  logic [INS_W-1:0]  main_ins,      skid_ins;
  logic [PC_W-1:0]   main_pc,       skid_pc;
  logic [DATA_W-1:0] main_data,     skid_data;
  logic              main_regwrite, skid_regwrite;
  logic [REGA_W-1:0] main_regwa,    skid_regwa;
  logic [TNEW_W-1:0] main_tnew,     skid_tnew;

  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;

  logic [INS_W-1:0]  main_d_ins;
  logic [PC_W-1:0]   main_d_pc;
  logic [DATA_W-1:0] main_d_data;
  logic              main_d_regwrite;
  logic [REGA_W-1:0] main_d_regwa;
  logic [TNEW_W-1:0] main_d_tnew;

  // Next-state and load-enable decode. Loads are gated by clear so that a
  // flushed cycle never captures the incoming entry.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          main_load  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Head leaves and the new entry replaces it in the same cycle.
          main_load = 1'b1;
        end else if (push) begin
          skid_load  = 1'b1;
          state_next = FULL;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    if (clear) begin
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_comb begin
    if (main_from_skid) begin
      main_d_ins      = skid_ins;
      main_d_pc       = skid_pc;
      main_d_data     = skid_data;
      main_d_regwrite = skid_regwrite;
      main_d_regwa    = skid_regwa;
      main_d_tnew     = skid_tnew;
    end else begin
      main_d_ins      = in_ins;
      main_d_pc       = in_pc;
      main_d_data     = in_data;
      main_d_regwrite = in_regwrite;
      main_d_regwa    = in_regwa;
      main_d_tnew     = cap_tnew;
    end
  end

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .TNEW_W (TNEW_W)
  ) u_main (
    .clk        (clk),
    .clear      (clear),
    .load       (main_load),
    .d_ins      (main_d_ins),
    .d_pc       (main_d_pc),
    .d_data     (main_d_data),
    .d_regwrite (main_d_regwrite),
    .d_regwa    (main_d_regwa),
    .d_tnew     (main_d_tnew),
    .q_ins      (main_ins),
    .q_pc       (main_pc),
    .q_data     (main_data),
    .q_regwrite (main_regwrite),
    .q_regwa    (main_regwa),
    .q_tnew     (main_tnew)
  );

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .TNEW_W (TNEW_W)
  ) u_skid (
    .clk        (clk),
    .clear      (clear),
    .load       (skid_load),
    .d_ins      (in_ins),
    .d_pc       (in_pc),
    .d_data     (in_data),
    .d_regwrite (in_regwrite),
    .d_regwa    (in_regwa),
    .d_tnew     (cap_tnew),
    .q_ins      (skid_ins),
    .q_pc       (skid_pc),
    .q_data     (skid_data),
    .q_regwrite (skid_regwrite),
    .q_regwa    (skid_regwa),
    .q_tnew     (skid_tnew)
  );

  // -------------------------------------------------------------------------
  // State machine with registered in_ready
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      in_ready_reg <= 1'b1;
    end else if (flush) begin
      state        <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state        <= state_next;
      in_ready_reg <= (state_next != FULL);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: head entry, or a zero bubble when nothing is held
  // -------------------------------------------------------------------------
  assign out_ins      = out_valid ? main_ins      : '0;
  assign out_pc       = out_valid ? main_pc       : '0;
  assign out_data     = out_valid ? main_data     : '0;
  assign out_regwrite = out_valid ? main_regwrite : 1'b0;
  assign out_regwa    = out_valid ? main_regwa    : '0;
  assign out_tnew     = out_valid ? main_tnew     : '0;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Checks two instances (Tnew decrement on / off) sharing the same stimulus
//   against a queue-based model of a 2-deep in-order stage.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int VW = 1 + 32 + 32 + DW + 1 + 5 + 2 + 2 + 1;

  logic clk;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] in_ins, in_pc;
  logic [DW-1:0] in_data;
  logic in_regwrite;
  logic [4:0] in_regwa;
  logic [1:0] in_tnew;

  logic in_ready, out_valid, out_regwrite;
  logic [31:0] out_ins, out_pc;
  logic [DW-1:0] out_data;
  logic [4:0] out_regwa;
  logic [1:0] out_tnew, occupancy;

  logic n_in_ready, n_out_valid, n_out_regwrite;
  logic [31:0] n_out_ins, n_out_pc;
  logic [DW-1:0] n_out_data;
  logic [4:0] n_out_regwa;
  logic [1:0] n_out_tnew, n_occupancy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0]   ins;
    logic [31:0]   pc;
    logic [DW-1:0] data;
    logic          rw;
    logic [4:0]    wa;
    logic [1:0]    tnew;
  } ent_t;

  ent_t q[$];

  pipe_stage_reg #(.DATA_W(DW), .TNEW_W(2), .TNEW_DEC(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .in_data(in_data),
    .in_regwrite(in_regwrite), .in_regwa(in_regwa), .in_tnew(in_tnew),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_pc(out_pc), .out_data(out_data),
    .out_regwrite(out_regwrite), .out_regwa(out_regwa), .out_tnew(out_tnew),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.DATA_W(DW), .TNEW_W(2), .TNEW_DEC(0)) dut_nodec (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .in_data(in_data),
    .in_regwrite(in_regwrite), .in_regwa(in_regwa), .in_tnew(in_tnew),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_ins(n_out_ins), .out_pc(n_out_pc), .out_data(n_out_data),
    .out_regwrite(n_out_regwrite), .out_regwa(n_out_regwa), .out_tnew(n_out_tnew),
    .occupancy(n_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observable state for one instance, from the model queue.
  function automatic logic [VW-1:0] exp_one(bit dec);
    logic [1:0] t;
    if (q.size() > 0) begin
      t = q[0].tnew;
      if (dec) t = (t == 2'd0) ? 2'd0 : t - 2'd1;
      return {1'b1, q[0].ins, q[0].pc, q[0].data, q[0].rw, q[0].wa, t,
              2'(q.size()), 1'(q.size() < 2)};
    end
    return {1'b0, 32'd0, 32'd0, {DW{1'b0}}, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1};
  endfunction

  function automatic logic [2*VW-1:0] exp_vec();
    return {exp_one(1'b1), exp_one(1'b0)};
  endfunction

  // Payload data is only meaningful while valid.
  function automatic logic [2*VW-1:0] act_vec();
    return {out_valid, out_ins, out_pc, (out_valid ? out_data : {DW{1'b0}}),
            out_regwrite, out_regwa, out_tnew, occupancy, in_ready,
            n_out_valid, n_out_ins, n_out_pc, (n_out_valid ? n_out_data : {DW{1'b0}}),
            n_out_regwrite, n_out_regwa, n_out_tnew, n_occupancy, n_in_ready};
  endfunction

  // One clock: update the model from the inputs seen at the edge, then move
  // to the falling edge where outputs are sampled.
  task automatic tick();
    ent_t e;
    bit p_push, p_pop;
    @(posedge clk);
    p_push = in_valid && (q.size() < 2);
    p_pop  = (q.size() > 0) && out_ready;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (p_pop) void'(q.pop_front());
      if (p_push) begin
        e.ins = in_ins; e.pc = in_pc; e.data = in_data;
        e.rw = in_regwrite; e.wa = in_regwa; e.tnew = in_tnew;
        q.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_entry(input logic [31:0] pc);
    in_ins      = $urandom;
    in_pc       = pc;
    in_data     = {$urandom, $urandom};
    in_regwrite = 1'($urandom);
    in_regwa    = 5'($urandom);
    in_tnew     = 2'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    rand_entry(32'h1234);
    tick(); tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_vec cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
    end
    total++;
    if ({out_valid, out_pc, out_regwa, occupancy, in_ready} !== {1'b0, 32'd0, 5'd0, 2'd0, 1'b1}) begin
      bad++; $display("FAIL reset_state cyc=%0d got=%h want=%h", cyc,
                      {out_valid, out_pc, out_regwa, occupancy, in_ready}, {1'b0, 32'd0, 5'd0, 2'd0, 1'b1});
    end
  endtask

  task automatic test_basic();
    rand_entry(32'h3000);
    in_ins = 32'h00851020; in_tnew = 2'd2; in_regwa = 5'd2; in_regwrite = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_pc, out_tnew, out_regwrite} !== {1'b1, 32'h3000, 2'd1, 1'b1}) begin
      bad++; $display("FAIL basic_out cyc=%0d got=%h want=%h", cyc,
                      {out_valid, out_pc, out_tnew, out_regwrite}, {1'b1, 32'h3000, 2'd1, 1'b1});
    end
    tick();
    total++;
    if ({out_valid, out_regwrite} !== 2'b00) begin
      bad++; $display("FAIL basic_bubble cyc=%0d got=%b want=00", cyc, {out_valid, out_regwrite});
    end
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++; $display("FAIL basic_vec cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_entry(32'h3000); tick();
    rand_entry(32'h3004); tick();
    in_valid = 1'b0;
    total++;
    if ({occupancy, in_ready, out_pc} !== {2'd2, 1'b0, 32'h3000}) begin
      bad++; $display("FAIL bp_full cyc=%0d got=%h want=%h", cyc,
                      {occupancy, in_ready, out_pc}, {2'd2, 1'b0, 32'h3000});
    end
    tick();
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++; $display("FAIL bp_hold_vec cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, out_pc, in_ready, occupancy} !== {1'b1, 32'h3004, 1'b1, 2'd1}) begin
      bad++; $display("FAIL bp_first_pop cyc=%0d got=%h want=%h", cyc,
                      {out_valid, out_pc, in_ready, occupancy}, {1'b1, 32'h3004, 1'b1, 2'd1});
    end
    tick();
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++; $display("FAIL bp_drain_vec cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
    end
  endtask

  task automatic test_tnew_sat();
    out_ready = 1'b1; in_valid = 1'b1;
    rand_entry(32'h5000); in_tnew = 2'd0;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_tnew, n_out_tnew} !== {2'd0, 2'd0}) begin
      bad++; $display("FAIL tnew_sat0 cyc=%0d got=%h want=0", cyc, {out_tnew, n_out_tnew});
    end
    in_valid = 1'b1;
    rand_entry(32'h5004); in_tnew = 2'd2;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_tnew, n_out_tnew} !== {2'd1, 2'd2}) begin
      bad++; $display("FAIL tnew_pass cyc=%0d got=%h want=%h", cyc, {out_tnew, n_out_tnew}, {2'd1, 2'd2});
    end
    tick();
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++; $display("FAIL tnew_vec cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
    end
  endtask

  task automatic fill_full();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_entry(32'h6000); tick();
    rand_entry(32'h6004); tick();
  endtask

  task automatic test_flush_full();
    fill_full();
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'($urandom);
    rand_entry(32'h4000); in_regwa = 5'd7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({occupancy, out_valid, out_regwa, in_ready} !== {2'd0, 1'b0, 5'd0, 1'b1}) begin
      bad++; $display("FAIL flush_empty cyc=%0d got=%h want=%h", cyc,
                      {occupancy, out_valid, out_regwa, in_ready}, {2'd0, 1'b0, 5'd0, 1'b1});
    end
    tick();
    total++;
    if ({out_valid, out_pc} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL flush_no_capture cyc=%0d got=%h want=0", cyc, {out_valid, out_pc});
    end
    // Flush from ONE while pushing: the pushed entry must also be dropped.
    in_valid = 1'b1; out_ready = 1'b0; rand_entry(32'h4100); tick();
    flush = 1'b1; rand_entry(32'h4104); tick();
    flush = 1'b0; in_valid = 1'b0; tick();
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++; $display("FAIL flush_one_vec cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_vs_flush();
    fill_full();
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    rand_entry(32'h7000);
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, out_ins, out_pc, out_regwrite, out_regwa, out_tnew, occupancy, in_ready}
        !== {1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1}) begin
      bad++; $display("FAIL rst_flush cyc=%0d got=%h want=%h", cyc,
                      {out_valid, out_ins, out_pc, out_regwrite, out_regwa, out_tnew, occupancy, in_ready},
                      {1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1});
    end
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_entry(32'h3000 + 32'(4 * i));
      tick();
      total++;
      if ({out_valid, occupancy, out_pc} !== {1'b1, 2'd1, 32'h3000 + 32'(4 * i)}) begin
        bad++; $display("FAIL stream_%0d cyc=%0d got=%h want=%h", i, cyc,
                        {out_valid, occupancy, out_pc}, {1'b1, 2'd1, 32'h3000 + 32'(4 * i)});
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++; $display("FAIL stream_end_vec cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(24) == 0);
      reset     = ($urandom_range(59) == 0);
      rand_entry($urandom);
      tick();
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_%0d cyc=%0d got=%h want=%h", i, cyc, act_vec(), exp_vec());
      end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ins = '0; in_pc = '0; in_data = '0; in_regwrite = 1'b0; in_regwa = '0; in_tnew = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_tnew_sat();
    test_flush_full();
    test_reset_vs_flush();
    test_streaming();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the generic payload (e.g. RD1 and RD2).
REQ-002 SHALL have parameter TNEW_W, default 2, Tnew field width.
REQ-003 SHALL have parameter TNEW_DEC, default 1; 1 means decrement Tnew on capture, 0 means pass it through.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port flush, input, 1, discards all held entries.
REQ-007 SHALL have port in_valid, input, 1, upstream entry present.
REQ-008 SHALL have port in_ready, output, 1, stage accepts an entry this cycle.
REQ-009 SHALL have ports in_ins (32), in_pc (32), in_data (DATA_W), in_regwrite (1), in_regwa (5) and in_tnew (TNEW_W), all inputs forming the entry fields.
REQ-010 SHALL have port out_valid, output, 1, head entry present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the head entry.
REQ-012 SHALL have ports out_ins, out_pc, out_data, out_regwrite, out_regwa and out_tnew, all outputs carrying the head entry fields.
REQ-013 SHALL have port occupancy, output, 2, number of held entries (0..2).

Function
REQ-014 SHALL hold up to 2 entries: a main register that drives the outputs, plus a skid register.
REQ-015 SHALL have states EMPTY, ONE and FULL, with occupancy equal to 0, 1 and 2 respectively.
REQ-016 SHALL make in_ready a registered signal, high exactly when the state is not FULL; it SHALL NOT depend combinationally on out_ready.
REQ-017 SHALL define push as in_valid && in_ready, and pop as out_valid && out_ready.
REQ-018 SHALL make transitions as follows: push without pop moves up one state; pop without push moves down one state; push with pop holds the state.
REQ-019 SHALL, on a simultaneous push and pop in ONE, load the new entry into main in the same cycle (1-cycle latency).
REQ-020 SHALL, on pop from FULL, move skid to main; a simultaneous push in FULL is impossible because in_ready is low.
REQ-021 SHALL preserve order: entries leave in push order, with no loss or duplication.
REQ-022 SHALL give an entry pushed into EMPTY out_valid high at the next rising edge.
REQ-023 SHALL, when TNEW_DEC=1, store Tnew as in_tnew-1 on capture, saturating at 0; when TNEW_DEC=0, it SHALL store in_tnew unchanged.
REQ-024 SHALL force out_regwrite=0, out_regwa=0, out_tnew=0, out_ins=0 and out_pc=0 while out_valid=0 (bubble), so hazard logic sees no producer.
REQ-025 SHALL, when flush=1, move to EMPTY with occupancy 0 at the next edge, ignoring push and pop that cycle; in_ready SHALL be 1 the following cycle.
REQ-026 SHALL leave skid contents don't-care when not occupied, but they SHALL never appear on the outputs.

Reset
REQ-027 SHALL give reset priority over flush, push and pop.
REQ-028 SHALL, at the reset edge, make the state EMPTY, occupancy 0, in_ready 1, out_valid 0 and all out_* fields 0.
REQ-029 SHALL apply reset unconditionally; there is no enable gating.
REQ-030 SHALL make reset asserted mid-operation in FULL discard both entries.
REQ-031 SHALL ensure no register has an initial-block dependence; reset alone defines all register state.

Structure
REQ-032 SHALL place the state encoding (EMPTY=0, ONE=1, FULL=2) and the default TNEW_W in the shared cpu package.
REQ-033 SHALL implement each entry as an instance of sub-module pipe_entry_reg, a load-enabled field register with synchronous clear, instantiated twice (main and skid).
REQ-034 SHALL contain the state machine and the Tnew decrement in pipe_stage_reg itself.

Verification
REQ-035 SHALL cover basic flow: reset; push ins=0x00851020, pc=0x3000, tnew=2, regwa=2, regwrite=1; out_ready=1 -> next cycle out_valid=1, out_pc=0x3000, out_tnew=1, following cycle out_valid=0 and out_regwrite=0.
REQ-036 SHALL cover backpressure: out_ready=0 while pushing pc 0x3000 then 0x3004 -> occupancy 2, in_ready=0, out_pc held at 0x3000; raise out_ready -> 0x3000 then 0x3004 emitted in order, in_ready=1 after the first pop.
REQ-037 SHALL cover Tnew saturation: push with tnew=0, TNEW_DEC=1 -> out_tnew=0; with TNEW_DEC=0 and tnew=2 -> out_tnew=2.
REQ-038 SHALL cover flush in FULL together with in_valid=1: next cycle occupancy 0, out_valid=0, out_regwa=0, and the flushed-cycle input is not captured.
REQ-039 SHALL cover reset versus flush: in FULL, assert reset and flush together with push and pop -> EMPTY, all outputs 0, in_ready=1.
REQ-040 SHALL cover streaming: in_valid=1 and out_ready=1 for 16 cycles with pc 0x3000 incremented by 4 -> one entry per cycle after 1-cycle latency, occupancy stays 1, no gaps.
